// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-port arbiter and slot sequencer for the two-phase register file
module regfile_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              p0_req,
    output logic              p0_gnt,
    input  logic [ADDR_W-1:0] p0_rega_addr,
    input  logic [ADDR_W-1:0] p0_regb_addr,
    input  logic              p0_wr_en,
    input  logic [ADDR_W-1:0] p0_wr_addr,
    input  logic [DATA_W-1:0] p0_wr_data,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata_a,
    output logic [DATA_W-1:0] p0_rdata_b,
    input  logic              p1_req,
    output logic              p1_gnt,
    input  logic [ADDR_W-1:0] p1_rega_addr,
    input  logic [ADDR_W-1:0] p1_regb_addr,
    input  logic              p1_wr_en,
    input  logic [ADDR_W-1:0] p1_wr_addr,
    input  logic [DATA_W-1:0] p1_wr_data,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata_a,
    output logic [DATA_W-1:0] p1_rdata_b,
    output logic [ADDR_W-1:0] rf_rega_addr,
    output logic [ADDR_W-1:0] rf_regb_addr,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    input  logic [DATA_W-1:0] rf_rega_data,
    input  logic [DATA_W-1:0] rf_regb_data,
    output logic              busy
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLOT_A = 2'd1,
        SLOT_B = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic              can_grant;
    logic              p1_wins;
    logic              any_gnt;

    logic              lat_owner;
    logic              lat_wr_en;

    logic              cap_vld;
    logic              cap_owner;
    logic              cap_byp_a;
    logic              cap_byp_b;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] cap_rdata_a;
    logic [DATA_W-1:0] cap_rdata_b;

    // Grants are only offered at slot boundaries so each slot spans one read and one write edge.
    always_comb begin
        can_grant = RESETN && (state == IDLE || state == SLOT_B);
        p1_wins   = p1_req && (!p0_req || starve_cnt == LIMIT);
        p0_gnt    = can_grant && p0_req && !p1_wins;
        p1_gnt    = can_grant && p1_wins;
        any_gnt   = p0_gnt || p1_gnt;
        state_nxt = state;
        case (state)
            IDLE:    if (any_gnt) state_nxt = SLOT_A;
            SLOT_A:  state_nxt = SLOT_B;
            SLOT_B:  state_nxt = any_gnt ? SLOT_A : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (!p1_req || p1_gnt) begin
                starve_cnt <= '0;
            end else if (p0_gnt) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // The latch registers drive the register file directly and hold when idle.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            lat_owner     <= 1'b0;
            lat_wr_en     <= 1'b0;
            rf_rega_addr  <= '0;
            rf_regb_addr  <= '0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
        end else if (any_gnt) begin
            lat_owner     <= p1_gnt;
            lat_wr_en     <= p1_gnt ? p1_wr_en     : p0_wr_en;
            rf_rega_addr  <= p1_gnt ? p1_rega_addr : p0_rega_addr;
            rf_regb_addr  <= p1_gnt ? p1_regb_addr : p0_regb_addr;
            rf_write_addr <= p1_gnt ? p1_wr_addr   : p0_wr_addr;
            rf_write_data <= p1_gnt ? p1_wr_data   : p0_wr_data;
        end
    end

    assign busy            = (state != IDLE);
    assign rf_write_enable = lat_wr_en && busy;

    // Slot context is copied out at the end of SLOT_B because the latches may be reloaded there.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            cap_vld   <= 1'b0;
            cap_owner <= 1'b0;
            cap_byp_a <= 1'b0;
            cap_byp_b <= 1'b0;
            cap_wdata <= '0;
        end else begin
            cap_vld   <= (state == SLOT_B);
            cap_owner <= lat_owner;
            cap_byp_a <= lat_wr_en && (rf_write_addr == rf_rega_addr);
            cap_byp_b <= lat_wr_en && (rf_write_addr == rf_regb_addr);
            cap_wdata <= rf_write_data;
        end
    end

    assign cap_rdata_a = cap_byp_a ? cap_wdata : rf_rega_data;
    assign cap_rdata_b = cap_byp_b ? cap_wdata : rf_regb_data;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            p0_rdata_a <= '0;
            p0_rdata_b <= '0;
            p1_rdata_a <= '0;
            p1_rdata_b <= '0;
        end else begin
            p0_rvalid <= cap_vld && !cap_owner;
            p1_rvalid <= cap_vld && cap_owner;
            if (cap_vld && !cap_owner) begin
                p0_rdata_a <= cap_rdata_a;
                p0_rdata_b <= cap_rdata_b;
            end
            if (cap_vld && cap_owner) begin
                p1_rdata_a <= cap_rdata_a;
                p1_rdata_b <= cap_rdata_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - scoreboard bench for regfile_arbiter with a free-running two-phase register file
module tb_regfile_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          RESETN;
    logic          p0_req, p0_gnt, p0_wr_en, p0_rvalid;
    logic [AW-1:0] p0_rega_addr, p0_regb_addr, p0_wr_addr;
    logic [DW-1:0] p0_wr_data, p0_rdata_a, p0_rdata_b;
    logic          p1_req, p1_gnt, p1_wr_en, p1_rvalid;
    logic [AW-1:0] p1_rega_addr, p1_regb_addr, p1_wr_addr;
    logic [DW-1:0] p1_wr_data, p1_rdata_a, p1_rdata_b;
    logic [AW-1:0] rf_rega_addr, rf_regb_addr, rf_write_addr;
    logic [DW-1:0] rf_write_data, rf_rega_data, rf_regb_data;
    logic          rf_write_enable, busy;

    regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .p0_req(p0_req), .p0_gnt(p0_gnt), .p0_rega_addr(p0_rega_addr), .p0_regb_addr(p0_regb_addr),
        .p0_wr_en(p0_wr_en), .p0_wr_addr(p0_wr_addr), .p0_wr_data(p0_wr_data),
        .p0_rvalid(p0_rvalid), .p0_rdata_a(p0_rdata_a), .p0_rdata_b(p0_rdata_b),
        .p1_req(p1_req), .p1_gnt(p1_gnt), .p1_rega_addr(p1_rega_addr), .p1_regb_addr(p1_regb_addr),
        .p1_wr_en(p1_wr_en), .p1_wr_addr(p1_wr_addr), .p1_wr_data(p1_wr_data),
        .p1_rvalid(p1_rvalid), .p1_rdata_a(p1_rdata_a), .p1_rdata_b(p1_rdata_b),
        .rf_rega_addr(rf_rega_addr), .rf_regb_addr(rf_regb_addr), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .rf_write_enable(rf_write_enable),
        .rf_rega_data(rf_rega_data), .rf_regb_data(rf_regb_data), .busy(busy)
    );

    // Register file: read edge and write edge alternate forever, no reset.
    logic [DW-1:0] rf_mem [16] = '{default: '0};
    logic          rf_phase = 1'b0;
    always @(posedge CLK) begin
        rf_phase <= ~rf_phase;
        if (rf_phase) begin
            rf_rega_data <= rf_mem[rf_rega_addr];
            rf_regb_data <= rf_mem[rf_regb_addr];
        end else if (rf_write_enable) begin
            rf_mem[rf_write_addr] <= rf_write_data;
        end
    end

    typedef struct packed { logic [AW-1:0] ra; logic [AW-1:0] rb; logic we; logic [AW-1:0] wa; logic [DW-1:0] wd; } tx_t;
    typedef struct packed { logic [DW-1:0] a; logic [DW-1:0] b; int due; } exp_t;

    tx_t           s0[$], s1[$];
    exp_t          e0[$], e1[$];
    int            g_port[$], g_cyc[$];
    logic [DW-1:0] ref_mem [16];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic tx_t mk(input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic we,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        tx_t t;
        t.ra = ra; t.rb = rb; t.we = we; t.wa = wa; t.wd = wd;
        return t;
    endfunction

    function automatic tx_t rnd_tx();
        tx_t t;
        t.ra = 4'($urandom_range(0, 15));
        t.rb = 4'($urandom_range(0, 15));
        t.we = 1'($urandom_range(0, 1));
        t.wa = 4'($urandom_range(0, 15));
        t.wd = 16'($urandom);
        return t;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic drive_ports();
        p0_req = (s0.size() != 0);
        if (s0.size() != 0) begin
            p0_rega_addr = s0[0].ra; p0_regb_addr = s0[0].rb;
            p0_wr_en = s0[0].we; p0_wr_addr = s0[0].wa; p0_wr_data = s0[0].wd;
        end
        p1_req = (s1.size() != 0);
        if (s1.size() != 0) begin
            p1_rega_addr = s1[0].ra; p1_regb_addr = s1[0].rb;
            p1_wr_en = s1[0].we; p1_wr_addr = s1[0].wa; p1_wr_data = s1[0].wd;
        end
    endtask

    // Reference model: transactions take effect in grant order, with same-slot bypass.
    task automatic on_grant();
        tx_t  t;
        exp_t e;
        if (p0_gnt || p1_gnt) begin
            t = p1_gnt ? s1[0] : s0[0];
            e.a = (t.we && t.wa == t.ra) ? t.wd : ref_mem[t.ra];
            e.b = (t.we && t.wa == t.rb) ? t.wd : ref_mem[t.rb];
            e.due = cyc + 4;
            if (t.we) ref_mem[t.wa] = t.wd;
            g_port.push_back(p1_gnt ? 1 : 0);
            g_cyc.push_back(cyc);
            if (p1_gnt) begin
                e1.push_back(e);
                s1.delete(0);
            end else begin
                e0.push_back(e);
                s0.delete(0);
            end
        end
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        tick();
        tick();
        @(negedge CLK);
        n_cmp++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rf_write_enable, busy} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 000000", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rf_write_enable, busy});
        end
        n_cmp++;
        if ({p0_rdata_a, p0_rdata_b, p1_rdata_a, p1_rdata_b} !== '0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h %h %h %h want 0", p0_rdata_a, p0_rdata_b, p1_rdata_a, p1_rdata_b);
        end
        n_cmp++;
        if ({rf_rega_addr, rf_regb_addr, rf_write_addr, rf_write_data} !== '0) begin
            n_err++;
            $display("FAIL reset_rf: got %h %h %h %h want 0", rf_rega_addr, rf_regb_addr, rf_write_addr, rf_write_data);
        end
        n_cmp++;
        if (dut.starve_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt);
        end
        RESETN = 1'b1;
        tick();
    endtask

    task automatic test_raw_bypass();
        exp_t ex;
        s0.push_back(mk(4'd3, 4'd0, 1'b1, 4'd3, 16'hBEEF));
        s0.push_back(mk(4'd3, 4'd3, 1'b0, 4'd0, 16'h0000));
        for (int i = 0; i < 20 && (s0.size() + e0.size()) != 0; i++) begin
            drive_ports();
            @(negedge CLK);
            on_grant();
            if (p0_rvalid) begin
                n_cmp++;
                ex = '0; ex.due = -1;
                if (e0.size() != 0) ex = e0.pop_front();
                if (p0_rdata_a !== ex.a || p0_rdata_b !== ex.b || cyc != ex.due) begin
                    n_err++;
                    $display("FAIL t1_p0_read: got a=%h b=%h cyc=%0d want a=%h b=%h cyc=%0d", p0_rdata_a, p0_rdata_b, cyc, ex.a, ex.b, ex.due);
                end
            end
            if (p1_rvalid) begin
                n_cmp++; n_err++;
                $display("FAIL t1_p1_rvalid: got 1 want 0 at cyc %0d", cyc);
            end
            tick();
        end
        n_cmp++;
        if ((s0.size() + e0.size()) != 0) begin
            n_err++;
            $display("FAIL t1_drain: got %0d pending want 0", s0.size() + e0.size());
        end
        n_cmp++;
        if (p0_rdata_a !== 16'hBEEF || p0_rdata_b !== 16'hBEEF) begin
            n_err++;
            $display("FAIL t1_r3_readback: got %h %h want beef beef", p0_rdata_a, p0_rdata_b);
        end
    endtask

    task automatic test_starvation();
        exp_t ex;
        g_port.delete(); g_cyc.delete();
        for (int i = 0; i < 20; i++) s0.push_back(rnd_tx());
        for (int i = 0; i < 8; i++) s1.push_back(rnd_tx());
        for (int i = 0; i < 80 && (s0.size() + s1.size() + e0.size() + e1.size()) != 0; i++) begin
            drive_ports();
            @(negedge CLK);
            n_cmp++;
            if (p0_gnt && p1_gnt) begin
                n_err++;
                $display("FAIL t2_gnt_exclusive: got both gnt at cyc %0d want one", cyc);
            end
            on_grant();
            if (g_port.size() >= 20) begin
                s0.delete();
                s1.delete();
            end
            if (p0_rvalid) begin
                n_cmp++;
                ex = '0; ex.due = -1;
                if (e0.size() != 0) ex = e0.pop_front();
                if (p0_rdata_a !== ex.a || p0_rdata_b !== ex.b || cyc != ex.due) begin
                    n_err++;
                    $display("FAIL t2_p0_read: got a=%h b=%h cyc=%0d want a=%h b=%h cyc=%0d", p0_rdata_a, p0_rdata_b, cyc, ex.a, ex.b, ex.due);
                end
            end
            if (p1_rvalid) begin
                n_cmp++;
                ex = '0; ex.due = -1;
                if (e1.size() != 0) ex = e1.pop_front();
                if (p1_rdata_a !== ex.a || p1_rdata_b !== ex.b || cyc != ex.due) begin
                    n_err++;
                    $display("FAIL t2_p1_read: got a=%h b=%h cyc=%0d want a=%h b=%h cyc=%0d", p1_rdata_a, p1_rdata_b, cyc, ex.a, ex.b, ex.due);
                end
            end
            tick();
        end
        n_cmp++;
        if (g_port.size() != 20 || (e0.size() + e1.size()) != 0) begin
            n_err++;
            $display("FAIL t2_grant_count: got %0d grants %0d pending want 20 grants 0 pending", g_port.size(), e0.size() + e1.size());
        end
        for (int k = 0; k < g_port.size() && k < 20; k++) begin
            n_cmp++;
            if (g_port[k] != ((k % 5 == 4) ? 1 : 0) || (k > 0 && (g_cyc[k] - g_cyc[k-1]) != 2)) begin
                n_err++;
                $display("FAIL t2_grant_seq: k=%0d got port %0d gap %0d want port %0d gap 2", k, g_port[k],
                         (k > 0) ? g_cyc[k] - g_cyc[k-1] : 2, (k % 5 == 4) ? 1 : 0);
            end
        end
    endtask

    task automatic test_phase_align();
        exp_t ex;
        int   lat [2];
        int   rel;
        int   nrv;
        for (int k = 0; k < 2; k++) begin
            RESETN = 1'b0;
            tick();
            tick();
            if ((cyc % 2) != k) tick();
            RESETN = 1'b1;
            rel = cyc;
            nrv = 0;
            lat[k] = -1;
            s0.push_back(mk(4'd1, 4'd2, 1'b1, 4'd5, 16'h00A5));
            s0.push_back(mk(4'd5, 4'd5, 1'b0, 4'd0, 16'h0000));
            for (int i = 0; i < 20 && (s0.size() + e0.size()) != 0; i++) begin
                drive_ports();
                @(negedge CLK);
                on_grant();
                if (p0_rvalid) begin
                    nrv++;
                    if (nrv == 2) lat[k] = cyc - rel;
                    n_cmp++;
                    ex = '0; ex.due = -1;
                    if (e0.size() != 0) ex = e0.pop_front();
                    if (p0_rdata_a !== ex.a || p0_rdata_b !== ex.b || cyc != ex.due) begin
                        n_err++;
                        $display("FAIL t3_p0_read: align=%0d got a=%h b=%h cyc=%0d want a=%h b=%h cyc=%0d", k, p0_rdata_a, p0_rdata_b, cyc, ex.a, ex.b, ex.due);
                    end
                end
                tick();
            end
            n_cmp++;
            if (lat[k] != 6 || p0_rdata_a !== 16'h00A5 || p0_rdata_b !== 16'h00A5) begin
                n_err++;
                $display("FAIL t3_align: align=%0d got lat %0d data %h %h want lat 6 data 00a5 00a5", k, lat[k], p0_rdata_a, p0_rdata_b);
            end
        end
        n_cmp++;
        if (lat[0] != lat[1]) begin
            n_err++;
            $display("FAIL t3_same_timing: got %0d vs %0d want equal", lat[0], lat[1]);
        end
    endtask

    task automatic test_cross_port();
        exp_t ex;
        int   c0 = -1;
        int   c1 = -1;
        s1.push_back(mk(4'd0, 4'd0, 1'b1, 4'd15, 16'h1234));
        for (int i = 0; i < 30 && (s0.size() + s1.size() + e0.size() + e1.size()) != 0; i++) begin
            drive_ports();
            @(negedge CLK);
            if (p1_gnt) s0.push_back(mk(4'd15, 4'd15, 1'b0, 4'd0, 16'h0000));
            on_grant();
            if (p0_rvalid) begin
                c0 = cyc;
                n_cmp++;
                ex = '0; ex.due = -1;
                if (e0.size() != 0) ex = e0.pop_front();
                if (p0_rdata_a !== ex.a || p0_rdata_b !== ex.b || cyc != ex.due) begin
                    n_err++;
                    $display("FAIL t4_p0_read: got a=%h b=%h cyc=%0d want a=%h b=%h cyc=%0d", p0_rdata_a, p0_rdata_b, cyc, ex.a, ex.b, ex.due);
                end
            end
            if (p1_rvalid) begin
                c1 = cyc;
                n_cmp++;
                ex = '0; ex.due = -1;
                if (e1.size() != 0) ex = e1.pop_front();
                if (p1_rdata_a !== ex.a || p1_rdata_b !== ex.b || cyc != ex.due) begin
                    n_err++;
                    $display("FAIL t4_p1_read: got a=%h b=%h cyc=%0d want a=%h b=%h cyc=%0d", p1_rdata_a, p1_rdata_b, cyc, ex.a, ex.b, ex.due);
                end
            end
            tick();
        end
        n_cmp++;
        if (c0 < 0 || c1 < 0 || (c0 - c1) != 2) begin
            n_err++;
            $display("FAIL t4_rvalid_order: got p1 at %0d p0 at %0d want p0 two cycles after p1", c1, c0);
        end
        n_cmp++;
        if (p0_rdata_a !== 16'h1234 || p0_rdata_b !== 16'h1234) begin
            n_err++;
            $display("FAIL t4_r15: got %h %h want 1234 1234", p0_rdata_a, p0_rdata_b);
        end
    endtask

    task automatic test_p1_alone();
        exp_t ex;
        g_port.delete(); g_cyc.delete();
        for (int i = 0; i < 3; i++) s1.push_back(rnd_tx());
        for (int i = 0; i < 30 && (s1.size() + e1.size()) != 0; i++) begin
            drive_ports();
            @(negedge CLK);
            on_grant();
            n_cmp++;
            if (dut.starve_cnt !== '0 || p0_rvalid !== 1'b0) begin
                n_err++;
                $display("FAIL t6_quiet_p0: got starve %0d p0_rvalid %b want 0 0", dut.starve_cnt, p0_rvalid);
            end
            if (p1_rvalid) begin
                n_cmp++;
                ex = '0; ex.due = -1;
                if (e1.size() != 0) ex = e1.pop_front();
                if (p1_rdata_a !== ex.a || p1_rdata_b !== ex.b || cyc != ex.due) begin
                    n_err++;
                    $display("FAIL t6_p1_read: got a=%h b=%h cyc=%0d want a=%h b=%h cyc=%0d", p1_rdata_a, p1_rdata_b, cyc, ex.a, ex.b, ex.due);
                end
            end
            tick();
        end
        n_cmp++;
        if (g_port.size() != 3 || (s1.size() + e1.size()) != 0) begin
            n_err++;
            $display("FAIL t6_grant_count: got %0d grants %0d pending want 3 grants 0 pending", g_port.size(), s1.size() + e1.size());
        end
        for (int k = 0; k < g_port.size() && k < 3; k++) begin
            n_cmp++;
            if (g_port[k] != 1 || (k > 0 && (g_cyc[k] - g_cyc[k-1]) != 2)) begin
                n_err++;
                $display("FAIL t6_grant_seq: k=%0d got port %0d gap %0d want port 1 gap 2", k, g_port[k], (k > 0) ? g_cyc[k] - g_cyc[k-1] : 2);
            end
        end
    endtask

    task automatic test_reset_abort();
        s0.push_back(mk(4'd9, 4'd9, 1'b1, 4'd9, 16'hDEAD));
        drive_ports();
        @(negedge CLK);
        n_cmp++;
        if (p0_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL t5_gnt: got %b want 1", p0_gnt);
        end
        on_grant();
        tick();
        drive_ports();
        RESETN = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (busy !== 1'b1 || rf_write_enable !== 1'b1) begin
            n_err++;
            $display("FAIL t5_slot_a: got busy %b we %b want 1 1", busy, rf_write_enable);
        end
        tick();
        @(negedge CLK);
        n_cmp++;
        if ({rf_write_enable, busy, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 6'b0 || rf_write_addr !== '0) begin
            n_err++;
            $display("FAIL t5_after_reset: got %b waddr %h want 000000 waddr 0",
                     {rf_write_enable, busy, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, rf_write_addr);
        end
        e0.delete();
        tick();
        RESETN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_ports();
            @(negedge CLK);
            n_cmp++;
            if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL t5_aborted: cyc %0d got rvalid %b %b busy %b want 0 0 0", cyc, p0_rvalid, p1_rvalid, busy);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        RESETN = 1'b0;
        p0_req = 1'b0; p0_rega_addr = '0; p0_regb_addr = '0; p0_wr_en = 1'b0; p0_wr_addr = '0; p0_wr_data = '0;
        p1_req = 1'b0; p1_rega_addr = '0; p1_regb_addr = '0; p1_wr_en = 1'b0; p1_wr_addr = '0; p1_wr_data = '0;
        tick();
        test_reset();
        test_raw_bypass();
        test_starvation();
        test_phase_align();
        test_cross_port();
        test_p1_alone();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the 16x16 two-phase register file between two requesters and sequences every access into it.
- Port 0 is the core datapath and has priority. Port 1 is the debug/loader path, protected by a starvation guard.
- The block hides the register file's alternating read-phase/write-phase behaviour. It presents each requester with a simple req/gnt and rvalid interface: two reads plus an optional write per transaction.

Parameters:
DATA_W, 16, register data width
ADDR_W, 4, register address width (2^ADDR_W registers)
STARVE_LIMIT, 4, consecutive port-0 grants allowed while port-1 req is pending

Ports:
CLK  in  1  system clock, rising edge
RESETN  in  1  synchronous active-low reset
p0_req  in  1  port-0 transaction request; hold with fields stable until p0_gnt
p0_gnt  out  1  one-cycle accept pulse; fields are latched at this edge
p0_rega_addr, p0_regb_addr  in  ADDR_W  read addresses
p0_wr_en  in  1  write requested in this transaction
p0_wr_addr  in  ADDR_W  write address
p0_wr_data  in  DATA_W  write data
p0_rvalid  out  1  one-cycle pulse; read results valid
p0_rdata_a, p0_rdata_b  out  DATA_W  read results, held until the next p0_rvalid
p1_*  same set as p0_*, for port 1
rf_rega_addr, rf_regb_addr, rf_write_addr  out  ADDR_W  to register file
rf_write_data  out  DATA_W  to register file
rf_write_enable  out  1  to register file
rf_rega_data, rf_regb_data  in  DATA_W  from register file
busy  out  1  high while a slot is in progress

Behaviour:
- Register file model:
  - It reads on one clock edge and writes on the next, alternating forever.
  - It has no reset, so its phase is unknown.
- Slot definition:
  - Each transaction occupies a 2-cycle slot, states SLOT_A then SLOT_B.
  - All rf_* outputs are held constant across both slots' cycles.
  - Any 2-cycle slot therefore contains exactly one read edge and one write edge, in either order.
- FSM states: IDLE, SLOT_A, SLOT_B.
  - IDLE -> SLOT_A when any req is granted.
  - SLOT_A -> SLOT_B unconditionally.
  - SLOT_B -> SLOT_A if a req is granted, else -> IDLE.
- Grant rules:
  - gnt is combinational from state and req, asserted only in IDLE or SLOT_B.
  - At most one gnt is high per cycle.
  - Request fields are latched at the gnt edge.
- Arbitration and starvation guard:
  - Port 0 wins unless starve_cnt == STARVE_LIMIT and p1_req is high.
  - starve_cnt increments on each p0 grant while p1_req is high.
  - starve_cnt clears on a p1 grant, or in any cycle where p1_req is low.
- rf_* timing:
  - rf_* outputs come from the latch registers during SLOT_A and SLOT_B.
  - rf_write_enable = latched wr_en during SLOT_A and SLOT_B, 0 otherwise.
  - Addresses and data hold their last values when idle.
- Capture:
  - rf_rega_data and rf_regb_data are sampled at the edge ending the cycle after SLOT_B, whether that cycle is IDLE or the next SLOT_A.
  - This sample is correct for either phase alignment.
  - rvalid of the owning port pulses in the following cycle.
- Latency: gnt in cycle t gives SLOT_A at t+1, SLOT_B at t+2, capture at the end of t+3, and rvalid in t+4.
- Throughput: one transaction per 2 cycles. The capture pipeline register holds the owner id so that overlapping slots do not collide.
- Bypass:
  - If the latched wr_en is set and wr_addr == rega_addr, rdata_a = latched wr_data. The same rule applies to regb_addr and rdata_b.
  - This makes a same-slot read-after-write deterministic.
  - Writes from earlier slots are always visible to later slots.
- Reset (RESETN low, sampled at an edge):
  - Next cycle: state IDLE, both gnt 0, both rvalid 0, rf_write_enable 0, busy 0, starve_cnt 0, capture pipeline cleared.
  - rdata outputs reset to 0; rf address and data outputs reset to 0.
  - A transaction in flight is aborted and produces no rvalid. Its write may or may not have landed, and the requester must reissue it.
- busy = (state != IDLE).

Test Plan:
1. Reset, then p0 req with wr_en=1, wr_addr=3, wr_data=0xBEEF, rega_addr=3, regb_addr=0 -> gnt in cycle t, p0_rvalid in t+4, rdata_a=0xBEEF via bypass. A following read of R3 returns 0xBEEF.
2. p0_req and p1_req both held high for 20 slots, STARVE_LIMIT=4 -> grant sequence p0,p0,p0,p0,p1 repeating, gnt spaced exactly 2 cycles apart.
3. Release reset on an even cycle and then on an odd cycle (both register-file phase alignments). Write R5=0x00A5, then read R5 -> 0x00A5 with identical rvalid timing in both runs.
4. p1 writes R15=0x1234; in the next slot p0 reads rega=15, regb=15 -> p0_rdata_a = p0_rdata_b = 0x1234, and p1_rvalid precedes p0_rvalid by 2 cycles.
5. Assert RESETN low during SLOT_A of a granted p0 write -> next cycle rf_write_enable=0, busy=0, both gnt=0, and no p0_rvalid ever appears for that transaction.
6. p1 alone requests while p0 is idle, for 3 transactions -> p1 is granted every 2 cycles, starve_cnt stays 0, and p0_rvalid never pulses.
